// File: rtl/rgmii_rx_frame_checker_pkg.sv
// Shared constants, status-word bit positions and state encoding for the
// RGMII receive frame checker.
package rgmii_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  // Highest preamble count before an SFD is mandatory.
  localparam logic [2:0]  PRE_MAX       = 3'd7;

  localparam int STAT_W       = 21;
  localparam int STAT_LEN_MSB = 15;
  localparam int STAT_CRC_OK  = 16;
  localparam int STAT_RX_ERR  = 17;
  localparam int STAT_RUNT    = 18;
  localparam int STAT_GIANT   = 19;
  localparam int STAT_ABORTED = 20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rgmii_rx_frame_checker_crc32_d8.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32 (LSB first).
module crc32_d8
  import rgmii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (CRC_POLY & {32{c[0] ^ data_in[i]}});
    end
    crc_out = c;
  end

endmodule

// File: rtl/rgmii_rx_frame_checker.sv
// Strips preamble/SFD, checks FCS/length/error flags, emits payload + status.
// Define RGMII_RX_FCS_STRIP_EN to hold back the last 4 bytes (FCS) of each frame.
module rgmii_rx_frame_checker
  import rgmii_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk375,
  input  logic        rst_n,
  input  logic [7:0]  Data_In,
  input  logic        Val_In,
  input  logic        Err_In,
  input  logic        SoF_In,
  input  logic        EoF_In,
  output logic [7:0]  Data_Out,
  output logic        Val_Out,
  output logic        SoF_Out,
  output logic        EoF_Out,
  output logic        Stat_Val,
  output logic [20:0] Stat,
  output logic [15:0] Bad_Pre_Cnt
);

  // All strobes are single-cycle, no backpressure: a byte is transferred in the
  // cycle Val_* is high; EoF_* and Stat_Val are standalone pulses with Val_*=0.

  rx_state_e         state_q, state_d, state_cur;
  logic [2:0]        pre_cnt_q, pre_cnt_d;
  logic [31:0]       crc_q, crc_d, crc_nxt;
  logic [15:0]       len_q, len_d;
  logic [15:0]       bad_q, bad_d;
  logic              rx_err_q, rx_err_d;
  logic              sof_done_q, sof_done_d;
  logic [7:0]        dout_q, dout_d;
  logic              vout_q, vout_d;
  logic              sout_q, sout_d;
  logic              eout_q, eout_d;
  logic              sval_q, sval_d;
  logic [STAT_W-1:0] stat_q, stat_d;
`ifdef RGMII_RX_FCS_STRIP_EN
  logic [31:0]       dline_q, dline_d;
  logic [2:0]        fill_q, fill_d;
`endif

  logic              sof_byte, eof_close, abort_close, close_frame;
  logic              frame_init, data_byte, emit;
  logic [7:0]        emit_byte;
  logic [1:0]        bad_inc;
  logic [16:0]       bad_sum;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (Data_In),
    .crc_out (crc_nxt)
  );

  function automatic logic [STAT_W-1:0] make_stat(input logic [15:0] len,
                                                  input logic [31:0] crc,
                                                  input logic        err,
                                                  input logic        aborted);
    logic [STAT_W-1:0] s;
    s                  = '0;
    s[STAT_LEN_MSB:0]  = len;
    s[STAT_CRC_OK]     = !aborted && (crc == CRC_RESIDUE);
    s[STAT_RX_ERR]     = err;
    s[STAT_RUNT]       = int'(len) < MIN_LEN;
    s[STAT_GIANT]      = int'(len) > MAX_LEN;
    s[STAT_ABORTED]    = aborted;
    return s;
  endfunction

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    crc_d      = crc_q;
    len_d      = len_q;
    rx_err_d   = rx_err_q;
    sof_done_d = sof_done_q;
    dout_d     = dout_q;
    vout_d     = 1'b0;
    sout_d     = 1'b0;
    eout_d     = 1'b0;
    sval_d     = 1'b0;
    stat_d     = stat_q;
`ifdef RGMII_RX_FCS_STRIP_EN
    dline_d    = dline_q;
    fill_d     = fill_q;
`endif
    bad_inc    = 2'd0;
    data_byte  = 1'b0;
    emit       = 1'b0;
    emit_byte  = Data_In;

    // EoF is handled before a coincident SoF, so state_cur is the post-EoF state.
    sof_byte    = Val_In && SoF_In;
    state_cur   = EoF_In ? IDLE : state_q;
    eof_close   = EoF_In && (state_q == DATA);
    abort_close = sof_byte && (state_cur == DATA);
    close_frame = eof_close || abort_close;
    if (EoF_In && (state_q == PREAMBLE))      bad_inc = bad_inc + 2'd1;
    if (sof_byte && (state_cur == PREAMBLE))  bad_inc = bad_inc + 2'd1;

    if (close_frame) begin
      sval_d = 1'b1;
      stat_d = make_stat(len_q, crc_q, rx_err_q, abort_close);
      eout_d = sof_done_q;
    end

    state_d = state_cur;
    if (sof_byte) begin
      if (Data_In == PREAMBLE_BYTE) begin
        state_d   = PREAMBLE;
        pre_cnt_d = 3'd1;
      end else if (Data_In == SFD_BYTE) begin
        state_d = DATA;
      end else begin
        state_d = DROP;
        bad_inc = bad_inc + 2'd1;
      end
    end else if (Val_In) begin
      case (state_cur)
        PREAMBLE: begin
          if ((Data_In == PREAMBLE_BYTE) && (pre_cnt_q < PRE_MAX)) begin
            pre_cnt_d = pre_cnt_q + 3'd1;
          end else if (Data_In == SFD_BYTE) begin
            state_d = DATA;
          end else begin
            state_d = DROP;
            bad_inc = bad_inc + 2'd1;
          end
        end
        DATA:    data_byte = 1'b1;
        default: ;
      endcase
    end

    frame_init = close_frame || ((state_d == DATA) && (state_cur != DATA));

    if (frame_init) begin
      crc_d      = CRC_INIT;
      len_d      = 16'd0;
      rx_err_d   = 1'b0;
      sof_done_d = 1'b0;
`ifdef RGMII_RX_FCS_STRIP_EN
      fill_d     = 3'd0;
`endif
    end else if (data_byte) begin
      crc_d    = crc_nxt;
      len_d    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
      rx_err_d = rx_err_q || Err_In;
`ifdef RGMII_RX_FCS_STRIP_EN
      // Oldest of the four held bytes sits in [7:0] once the line is full.
      dline_d = {Data_In, dline_q[31:8]};
      if (fill_q == 3'd4) begin
        emit      = 1'b1;
        emit_byte = dline_q[7:0];
      end else begin
        fill_d = fill_q + 3'd1;
      end
`else
      emit      = 1'b1;
      emit_byte = Data_In;
`endif
    end

    if (emit) begin
      vout_d     = 1'b1;
      dout_d     = emit_byte;
      sout_d     = !sof_done_q;
      sof_done_d = 1'b1;
    end

    bad_sum = {1'b0, bad_q} + {15'd0, bad_inc};
    bad_d   = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
  end

  always_ff @(posedge clk375) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_cnt_q  <= 3'd0;
      crc_q      <= CRC_INIT;
      len_q      <= 16'd0;
      bad_q      <= 16'd0;
      rx_err_q   <= 1'b0;
      sof_done_q <= 1'b0;
      dout_q     <= 8'd0;
      vout_q     <= 1'b0;
      sout_q     <= 1'b0;
      eout_q     <= 1'b0;
      sval_q     <= 1'b0;
      stat_q     <= '0;
`ifdef RGMII_RX_FCS_STRIP_EN
      dline_q    <= 32'd0;
      fill_q     <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      bad_q      <= bad_d;
      rx_err_q   <= rx_err_d;
      sof_done_q <= sof_done_d;
      dout_q     <= dout_d;
      vout_q     <= vout_d;
      sout_q     <= sout_d;
      eout_q     <= eout_d;
      sval_q     <= sval_d;
      stat_q     <= stat_d;
`ifdef RGMII_RX_FCS_STRIP_EN
      dline_q    <= dline_d;
      fill_q     <= fill_d;
`endif
    end
  end

  assign Data_Out    = dout_q;
  assign Val_Out     = vout_q;
  assign SoF_Out     = sout_q;
  assign EoF_Out     = eout_q;
  assign Stat_Val    = sval_q;
  assign Stat        = stat_q;
  assign Bad_Pre_Cnt = bad_q;

endmodule

// File: tb/tb_rgmii_rx_frame_checker.sv
// Directed bench for rgmii_rx_frame_checker: byte/status scoreboard plus
// direct checks of reset state and the bad-preamble counter.
module tb_rgmii_rx_frame_checker;

  localparam int W = 9;  // {sof, data}
`ifdef RGMII_RX_FCS_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  logic        clk375 = 1'b0;
  logic        rst_n  = 1'b0;
  logic [7:0]  Data_In = 8'd0;
  logic        Val_In = 1'b0, Err_In = 1'b0, SoF_In = 1'b0, EoF_In = 1'b0;
  logic [7:0]  Data_Out;
  logic        Val_Out, SoF_Out, EoF_Out, Stat_Val;
  logic [20:0] Stat;
  logic [15:0] Bad_Pre_Cnt;

  logic [W-1:0] exp_q[$];
  logic [21:0]  exp_stat_q[$];   // {eof_expected, stat}
  logic [7:0]   frame_b[$];
  logic [W-1:0] e_byte;
  logic [21:0]  e_stat;
  int           n_checks = 0;
  int           n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #2 clk375 = ~clk375;

  rgmii_rx_frame_checker dut (
    .clk375      (clk375),
    .rst_n       (rst_n),
    .Data_In     (Data_In),
    .Val_In      (Val_In),
    .Err_In      (Err_In),
    .SoF_In      (SoF_In),
    .EoF_In      (EoF_In),
    .Data_Out    (Data_Out),
    .Val_Out     (Val_Out),
    .SoF_Out     (SoF_Out),
    .EoF_Out     (EoF_Out),
    .Stat_Val    (Stat_Val),
    .Stat        (Stat),
    .Bad_Pre_Cnt (Bad_Pre_Cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [20:0] mk_stat(input int len, input bit ok, input bit err,
                                          input bit runt, input bit giant, input bit ab);
    return {ab, giant, runt, err, ok, 16'(len)};
  endfunction

  task automatic build_frame(input int npay, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    frame_b.delete();
    for (int i = 0; i < npay; i++) begin
      b = 8'(i * 13 + seed);
      frame_b.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    frame_b.push_back(c[7:0]);
    frame_b.push_back(c[15:8]);
    frame_b.push_back(c[23:16]);
    frame_b.push_back(c[31:24]);
  endtask

  // Pushes the payload bytes expected out of the first n received bytes.
  task automatic push_bytes(input int n, output int m);
    m = STRIP ? ((n > 4) ? n - 4 : 0) : n;
    for (int i = 0; i < m; i++) exp_q.push_back({(i == 0), frame_b[i]});
  endtask

  task automatic push_stat(input logic [20:0] s, input bit eof);
    exp_stat_q.push_back({eof, s});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_byte(input logic [7:0] d, input logic sof, input logic err);
    @(negedge clk375);
    Data_In = d; Val_In = 1'b1; SoF_In = sof; Err_In = err;
    @(negedge clk375);
    Val_In = 1'b0; SoF_In = 1'b0; Err_In = 1'b0;
    @(negedge clk375);
  endtask

  task automatic drive_eof();
    @(negedge clk375);
    EoF_In = 1'b1;
    @(negedge clk375);
    EoF_In = 1'b0;
    @(negedge clk375);
  endtask

  task automatic send_frame(input int nsend, input int err_idx, input bit do_eof);
    drive_byte(8'h55, 1'b1, 1'b0);
    repeat (6) drive_byte(8'h55, 1'b0, 1'b0);
    drive_byte(8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < nsend; i++) drive_byte(frame_b[i], 1'b0, (i == err_idx));
    if (do_eof) drive_eof();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_val_out"},  {31'd0, Val_Out},  32'd0);
    check({tag, "_sof_out"},  {31'd0, SoF_Out},  32'd0);
    check({tag, "_eof_out"},  {31'd0, EoF_Out},  32'd0);
    check({tag, "_stat_val"}, {31'd0, Stat_Val}, 32'd0);
    check({tag, "_data_out"}, {24'd0, Data_Out}, 32'd0);
    check({tag, "_stat"},     {11'd0, Stat},     32'd0);
    check({tag, "_bad_cnt"},  {16'd0, Bad_Pre_Cnt}, 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk375) begin
    if (rst_n) begin
      if (Val_Out) begin
        check("val_eof_overlap", {31'd0, EoF_Out}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {23'd0, SoF_Out, Data_Out}, 32'hFFFFFFFF);
        end else begin
          e_byte = exp_q.pop_front();
          check("payload", {23'd0, SoF_Out, Data_Out}, {23'd0, e_byte});
        end
      end
      if (Stat_Val) begin
        if (exp_stat_q.size() == 0) begin
          check("unexpected_stat", {10'd0, EoF_Out, Stat}, 32'hFFFFFFFF);
        end else begin
          e_stat = exp_stat_q.pop_front();
          check("stat", {10'd0, EoF_Out, Stat}, {10'd0, e_stat});
        end
      end else if (EoF_Out) begin
        check("eof_without_stat", 32'd1, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int m;
    repeat (4) @(negedge clk375);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk375);

    // Good 64-byte frame.
    build_frame(60, 1);
    push_bytes(64, m);
    push_stat(mk_stat(64, 1, 0, 0, 0, 0), m > 0);
    send_frame(64, -1, 1);

    // Same frame with payload byte 10 corrupted after FCS computation.
    frame_b[10] = frame_b[10] ^ 8'hFF;
    push_bytes(64, m);
    push_stat(mk_stat(64, 0, 0, 0, 0, 0), m > 0);
    send_frame(64, -1, 1);

    // Bad preamble: 0x55 0x55 0x5D ... then a good frame.
    drive_byte(8'h55, 1'b1, 1'b0);
    drive_byte(8'h55, 1'b0, 1'b0);
    drive_byte(8'h5D, 1'b0, 1'b0);
    drive_byte(8'hD5, 1'b0, 1'b0);
    drive_byte(8'h12, 1'b0, 1'b0);
    drive_eof();
    check("bad_pre_5d", {16'd0, Bad_Pre_Cnt}, 32'd1);
    build_frame(60, 2);
    push_bytes(64, m);
    push_stat(mk_stat(64, 1, 0, 0, 0, 0), m > 0);
    send_frame(64, -1, 1);
    check("bad_pre_after_good", {16'd0, Bad_Pre_Cnt}, 32'd1);

    // Eight 0x55 bytes: the eighth is illegal.
    drive_byte(8'h55, 1'b1, 1'b0);
    repeat (7) drive_byte(8'h55, 1'b0, 1'b0);
    drive_byte(8'hD5, 1'b0, 1'b0);
    drive_eof();
    check("bad_pre_8x55", {16'd0, Bad_Pre_Cnt}, 32'd2);

    // EoF while still in preamble.
    drive_byte(8'h55, 1'b1, 1'b0);
    drive_byte(8'h55, 1'b0, 1'b0);
    drive_eof();
    check("bad_pre_eof", {16'd0, Bad_Pre_Cnt}, 32'd3);

    // 100-byte frame aborted after 80 bytes by a new SoF, then a good frame.
    build_frame(96, 3);
    push_bytes(80, m);
    push_stat(mk_stat(80, 0, 0, 0, 0, 1), m > 0);
    send_frame(80, -1, 0);
    build_frame(60, 5);
    push_bytes(64, m);
    push_stat(mk_stat(64, 1, 0, 0, 0, 0), m > 0);
    send_frame(64, -1, 1);
    check("bad_pre_after_abort", {16'd0, Bad_Pre_Cnt}, 32'd3);

    // 44-byte runt with Err_In on byte 5.
    build_frame(40, 4);
    push_bytes(44, m);
    push_stat(mk_stat(44, 1, 1, 1, 0, 0), m > 0);
    send_frame(44, 5, 1);

    // Tiny 3-byte frame: no payload in strip build, status still issued.
    build_frame(0, 6);
    frame_b.delete();
    frame_b.push_back(8'hA1);
    frame_b.push_back(8'hB2);
    frame_b.push_back(8'hC3);
    push_bytes(3, m);
    push_stat(mk_stat(3, 0, 0, 1, 0, 0), m > 0);
    send_frame(3, -1, 1);

    // 1600-byte giant.
    build_frame(1596, 9);
    push_bytes(1600, m);
    push_stat(mk_stat(1600, 1, 0, 0, 1, 0), m > 0);
    send_frame(1600, -1, 1);

    // Reset mid-frame: bytes already out are expected, nothing afterwards.
    build_frame(60, 7);
    push_bytes(20, m);
    send_frame(20, -1, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk375);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk375);
    drive_eof();

    // Recovery frame after reset.
    build_frame(60, 8);
    push_bytes(64, m);
    push_stat(mk_stat(64, 1, 0, 0, 0, 0), m > 0);
    send_frame(64, -1, 1);

    for (int k = 0; k < 300 && (exp_q.size() != 0 || exp_stat_q.size() != 0); k++)
      @(negedge clk375);
    repeat (10) @(negedge clk375);
    check("bytes_drained", exp_q.size(), 32'd0);
    check("stats_drained", exp_stat_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_frame_checker.md
# rgmii_rx_frame_checker

Receive-side frame stage fed directly by the RGMII oversampling sampler, running in the clk375 domain. It consumes the sampler's sparse byte stream (Val/Err/SoF/EoF pulses), strips preamble and SFD, and checks the Ethernet FCS (CRC-32), frame length and error flags. It then emits the payload stream plus a per-frame status word to the MAC/packet buffer downstream.

## Interface
- MIN_LEN, 64: minimum legal frame length in bytes after SFD, FCS included.
- MAX_LEN, 1518: maximum legal frame length in bytes after SFD, FCS included.
- clk375  in  1  sole clock. The sampler's 375 MHz clock.
- rst_n  in  1  synchronous, active-low reset.
- Data_In  in  8  byte from the sampler, valid when Val_In=1.
- Val_In  in  1  one-cycle byte strobe. At most one per RXC period, never on consecutive cycles.
- Err_In  in  1  RX error qualifier, meaningful with Val_In.
- SoF_In  in  1  asserted with Val_In on the first byte of a burst (first preamble byte).
- EoF_In  in  1  one-cycle pulse with Val_In=0, one strobe slot after the last byte.
- Data_Out  out  8  payload byte.
- Val_Out  out  1  one-cycle payload strobe.
- SoF_Out  out  1  with Val_Out on the first payload byte (first byte after SFD).
- EoF_Out  out  1  one-cycle pulse with Val_Out=0, closing a frame.
- Stat_Val  out  1  one-cycle status strobe, same cycle as EoF_Out.
- Stat  out  21  [15:0] length (saturating at 16'hFFFF), [16] crc_ok, [17] rx_err, [18] runt, [19] giant, [20] aborted.
- Bad_Pre_Cnt  out  16  saturating count of bursts dropped for bad preamble/SFD.

## Operation
- States:
  - IDLE: wait for a byte with Val_In & SoF_In.
    - Byte 0x55 → PREAMBLE with pre_cnt=1.
    - Byte 0xD5 → DATA.
    - Any other byte → DROP.
  - PREAMBLE: on each Val_In byte:
    - 0x55 with pre_cnt<7 → pre_cnt++.
    - 0xD5 → DATA.
    - Anything else, including an 8th 0x55 → DROP.
    - EoF_In → IDLE, Bad_Pre_Cnt++.
  - DATA: each Val_In byte goes into the CRC, the length counter and the output path. Err_In sets rx_err. EoF_In → close frame, then IDLE.
  - DROP: ignore bytes. EoF_In → IDLE. Bad_Pre_Cnt++ on entry to DROP. No output, no Stat.
- CRC: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, computed over all bytes after SFD, FCS included. crc_ok=1 iff the final register equals residue 0xDEBB20E3.
- Close-frame behaviour:
  - Stat_Val pulses. runt=(length<MIN_LEN), giant=(length>MAX_LEN).
  - EoF_Out pulses only if SoF_Out was issued for the frame.
  - CRC, length, rx_err and aborted are re-initialised.
- Abort: SoF_In with Val_In in DATA or PREAMBLE.
  - From DATA: close the current frame with aborted=1, crc_ok=0.
  - From PREAMBLE: Bad_Pre_Cnt++ and no Stat.
  - Then process the new byte exactly as in IDLE, in the same cycle.
- If SoF_In and EoF_In coincide, EoF is processed first, then SoF.
- Bytes arriving while in IDLE without SoF_In are ignored.
- Bad_Pre_Cnt saturates at 16'hFFFF, and so does length.

## Timing
- Reset values:
  - All outputs 0, Bad_Pre_Cnt=0.
  - State IDLE, CRC=0xFFFFFFFF, delay line empty.
- Output latency without strip: Val_Out/Data_Out rise 1 cycle after the Val_In of the same byte.
- EoF_Out and Stat_Val occur 1 cycle after EoF_In, or 1 cycle after the aborting SoF_In.
- Val_Out never coincides with EoF_Out.
- A reset mid-frame discards everything: no EoF_Out, no Stat.

## Configuration
- RGMII_RX_FCS_STRIP_EN defined:
  - A 4-byte delay line holds bytes back. Payload byte n is emitted 1 cycle after the Val_In of byte n+4.
  - The FCS is never output.
  - Frames with ≤4 bytes after SFD produce no SoF_Out/EoF_Out; Stat still pulses.
- RGMII_RX_FCS_STRIP_EN undefined:
  - No delay line. All bytes after SFD, FCS included, pass with 1-cycle latency.
- Stat length and CRC check are identical in both builds.

## Structure
- Package rgmii_rx_pkg holds:
  - Constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_INIT, CRC_POLY, CRC_RESIDUE.
  - Stat bit-index constants.
  - The state encoding (IDLE, PREAMBLE, DATA, DROP).
- Sub-module crc32_d8: combinational next-CRC of 32-bit state + 8-bit byte, instantiated once.

## Test plan
Bytes are driven with Val_In every 3 cycles.
- Good frame: 7×0x55, 0xD5, 60 bytes, correct FCS → 64 bytes out (60 with strip), Stat=length 64, crc_ok=1, all other flags 0.
- Same frame with payload byte 10 flipped → identical output stream, crc_ok=0.
- Burst 0x55, 0x55, 0x5D, … → no output, no Stat, Bad_Pre_Cnt=1. A following good frame is received normally.
- Good 100-byte frame interrupted by SoF_In before EoF_In → Stat aborted=1, crc_ok=0. The new frame is received correctly.
- 40-byte frame with valid FCS and Err_In on byte 5 → Stat runt=1, rx_err=1, crc_ok=1, length 44.
- 1600-byte frame with valid FCS → giant=1, crc_ok=1. Reset mid-frame → all outputs 0 and no Stat.
